seq_add: RTL and testbench

SEQ_ADD -- requirements
Module: seq_add

---
 rtl/seq_add_pkg.sv | 23 ++
 rtl/seq_add_chunk_add.sv | 31 +++
 rtl/seq_add.sv | 151 +++++++++++++++
 tb/tb_seq_add.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_add_pkg.sv
// seq_add_pkg
//   Shared definitions for the chunk-serial adder/subtractor:
//   - state_e    : control FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - calc_n     : number of chunks N = W / C
//   - cnt_width  : width of the chunk counter (at least one bit, also for N=1)
package seq_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_n(input int w, input int c);
    return w / c;
  endfunction

  // A one-chunk configuration still needs a legal, non-zero-width counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_add_chunk_add.sv
// chunk_add
//   Purely combinational C-bit adder slice used once per RUN cycle.
//   Ports:
//     x, y   in  C  chunk operands
//     ci     in  1  carry into bit 0
//     s      out C  chunk sum
//     co     out 1  carry out of bit C-1
//     c_msb  out 1  carry into bit C-1 (feeds signed-overflow detection)
module chunk_add #(
  parameter int C = 8
) (
  input  logic [C-1:0] x,
  input  logic [C-1:0] y,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [C:0] total;

  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{C{1'b0}}, ci};
    s     = total[C-1:0];
    co    = total[C];
    // Sum bit = x ^ y ^ carry-in, so the carry into the top bit is recovered
    // from the sum bit; this also holds for C=1 where it equals ci.
    c_msb = total[C-1] ^ x[C-1] ^ y[C-1];
  end

endmodule

// File: rtl/seq_add.sv
// seq_add
//   Chunk-serial W-bit adder/subtractor. One C-bit chunk is processed per
//   RUN cycle (N = W/C cycles), then the result is published in DONE.
//   Subtraction is done as a + ~b + ~cin, so cout is "not borrow".
//   Ports:
//     clk   in  1  clock, rising edge
//     rst   in  1  synchronous active-high reset (clears all state)
//     start in  1  operation request, honoured only when busy=0
//     a, b  in  W  operands, captured on accepted start
//     cin   in  1  carry in (add) / borrow in (sub)
//     sub   in  1  0 = add, 1 = subtract
//     sum   out W  registered result, stable except on the DONE edge
//     cout  out 1  registered carry out / not-borrow
//     ovf   out 1  registered two's-complement overflow
//     busy  out 1  high while in RUN
//     done  out 1  one-cycle pulse in DONE
module seq_add
  import seq_add_pkg::*;
#(
  parameter int W = 32,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int                N     = calc_n(W, C);
  localparam int                CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;      // effective b (already inverted for sub)
  logic             carry_q, carry_d;  // carry into the chunk processed next
  logic [W-1:0]     acc_q,   acc_d;    // partial result, hidden from sum
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [C-1:0]     chunk_x, chunk_y, chunk_s;
  logic             chunk_co, chunk_c_msb;
  int unsigned      base;

  assign base    = C * int'(cnt_q);
  assign chunk_x = a_q[base +: C];
  assign chunk_y = b_q[base +: C];

  chunk_add #(.C(C)) u_chunk (
    .x     (chunk_x),
    .y     (chunk_y),
    .ci    (carry_q),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_c_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          // Subtract injects ~cin into chunk 0.
          carry_d = cin ^ sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d[base +: C] = chunk_s;
        carry_d          = chunk_co;
        if (cnt_q == LAST) begin
          // The chunk just added is the top one: publish everything now.
          sum_d   = acc_d;
          cout_d  = chunk_co;
          ovf_d   = chunk_c_msb ^ chunk_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_add.sv
// tb_seq_add
//   Randomized and directed bench for seq_add: a W=32/C=8 instance and a
//   W=8/C=8 (single-chunk) instance, checked against an arithmetic model.
module tb_seq_add;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // W=32, C=8 instance
  logic        start, cin, sub;
  logic [31:0] a, b, sum;
  logic        cout, ovf, busy, done;

  seq_add #(.W(32), .C(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  // W=8, C=8 instance
  logic       start8, cin8, sub8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, busy8, done8;

  seq_add #(.W(8), .C(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_sum;   // model's most recent published result (W=32)
  logic [7:0]  last_sum8;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer arithmetic on the full operands, overflow judged on
  // the signed interpretation, cout as unsigned carry / not-borrow.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit ci, input bit sb,
                                output longint s, output bit co, output bit ov);
    longint m, half, sa, sbv, u, t;
    m    = 64'sd1 <<< w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    if (!sb) begin
      u  = ua + ub + longint'(ci);
      co = (u >= m);
      t  = sa + sbv + longint'(ci);
    end else begin
      u  = ua - ub - longint'(ci);
      co = (u >= 0);
      t  = sa - sbv - longint'(ci);
    end
    s  = u & (m - 1);
    ov = (t > half - 1) || (t < -half);
  endfunction

  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input bit ici, input bit isb);
    longint es;
    bit     ec, eo;
    int     edges;
    model(32, longint'(ia), longint'(ib), ici, isb, es, ec, eo);
    a = ia; b = ib; cin = ici; sub = isb; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_hold"}, sum, last_sum);
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_lat"}, edges, 5);
    check({tag, "_sum"}, sum, es[31:0]);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    last_sum = es[31:0];
  endtask

  task automatic run_op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input bit ici, input bit isb);
    longint es;
    bit     ec, eo;
    int     edges;
    model(8, longint'(ia), longint'(ib), ici, isb, es, ec, eo);
    a8 = ia; b8 = ib; cin8 = ici; sub8 = isb; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    edges = 1;
    check({tag, "_busy"}, busy8, 1'b1);
    check({tag, "_hold"}, sum8, last_sum8);
    while (!done8 && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_lat"}, edges, 2);
    check({tag, "_sum"}, sum8, es[7:0]);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"}, ovf8, eo);
    last_sum8 = es[7:0];
  endtask

  initial begin
    logic [31:0] ra, rb, pick [5];
    longint      es;
    bit          ec, eo;
    int          edges, dones;

    rst = 1'b1; start = 0; a = 0; b = 0; cin = 0; sub = 0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    last_sum = '0; last_sum8 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum8", sum8, 8'h0);
    tick();
    check("idle_busy", busy, 1'b0);

    // Directed cases
    run_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick();
    check("pulse_done", done, 1'b0);
    check("pulse_busy", busy, 1'b0);
    run_op("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick();
    run_op("sub57", 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    run_op("sub75", 32'd7, 32'd5, 1'b1, 1'b1);
    tick();

    // Random cases, with corner values mixed in
    pick[0] = 32'h0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h7FFF_FFFF;
    pick[3] = 32'h8000_0000; pick[4] = 32'h00FF_FF00;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
      run_op("rnd", ra, rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    // Start held through RUN is ignored; start seen in DONE chains the next op
    rb = $urandom;
    a = 32'd1; b = rb; cin = 0; sub = 0; start = 1'b1;
    tick();
    a = 32'd9;
    edges = 1;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    model(32, 64'd1, longint'(rb), 1'b0, 1'b0, es, ec, eo);
    check("ign_lat", edges, 5);
    check("ign_sum", sum, es[31:0]);
    tick();
    start = 1'b0;
    edges = 1;
    check("b2b_busy", busy, 1'b1);
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    model(32, 64'd9, longint'(rb), 1'b0, 1'b0, es, ec, eo);
    check("b2b_gap", edges, 5);
    check("b2b_sum", sum, es[31:0]);
    last_sum = es[31:0];
    tick();

    // Reset in the 2nd RUN cycle aborts, and wins over a concurrent start
    a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 32'h0);
    last_sum = '0; last_sum8 = '0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort_nodone", dones, 0);

    // Single-chunk configuration
    run_op8("n1", 8'h80, 8'h80, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      run_op8("n1rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
